// File: rtl/cipher_round_ctrl.sv
// Iterative round sequencer for the 8-bit byte cipher.
// Sequences a bit-reversal block with rotating key add/subtract.
module cipher_round_bitrev (
    input  logic [7:0] in_data,
    output logic [7:0] out_data
);
    for (genvar i = 0; i < 8; i++) begin : g_rev
        assign out_data[i] = in_data[7-i];
    end
endmodule

module cipher_round_ctrl #(
    parameter int ROUNDS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_mode,
    input  logic [7:0] key,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic [2:0] round_idx
);
    if (ROUNDS < 1 || ROUNDS > 8) begin : g_bad_rounds
        $error("cipher_round_ctrl: ROUNDS must be in 1..8");
    end

    localparam logic [2:0] R_LAST = 3'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [7:0] key_q, key_d;
    logic [7:0] out_q, out_d;
    logic       mode_q, mode_d;
    logic [2:0] r_q, r_d;

    logic [15:0] rk_wide;
    logic [7:0]  rk;
    logic [7:0]  rev_in;
    logic [7:0]  rev_out;
    logic [7:0]  round_x;
    logic        last;

    // Rotate-left of the key by the round index via a doubled word.
    assign rk_wide = {key_q, key_q} << r_q;
    assign rk      = rk_wide[15:8];

    // Encrypt adds before the reversal, decrypt subtracts after it.
    assign rev_in  = mode_q ? x_q : 8'(x_q + rk);
    assign round_x = mode_q ? 8'(rev_out - rk) : rev_out;
    assign last    = mode_q ? (r_q == 3'd0) : (r_q == R_LAST);

    cipher_round_bitrev u_bitrev (
        .in_data (rev_in),
        .out_data(rev_out)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        key_d   = key_q;
        out_d   = out_q;
        mode_d  = mode_q;
        r_d     = r_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    key_d   = key;
                    mode_d  = in_mode;
                    r_d     = in_mode ? R_LAST : 3'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                x_d = round_x;
                if (last) begin
                    out_d   = round_x;
                    r_d     = 3'd0;
                    state_d = S_DONE;
                end else begin
                    r_d = mode_q ? r_q - 3'd1 : r_q + 3'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= 8'h00;
            key_q   <= 8'h00;
            out_q   <= 8'h00;
            mode_q  <= 1'b0;
            r_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            key_q   <= key_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            r_q     <= r_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign round_idx = (state_q == S_ROUND) ? r_q : 3'd0;
    assign out_data  = out_q;

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Bench for cipher_round_ctrl: ROUNDS=4 and ROUNDS=1 instances checked
// every cycle against a transaction-level model plus directed vectors.
module tb_cipher_round_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[2];
    logic       in_valid[2];
    logic       in_mode[2];
    logic       out_ready[2];
    logic [7:0] in_data[2];
    logic [7:0] key[2];
    logic       in_ready[2];
    logic       out_valid[2];
    logic       busy[2];
    logic [7:0] out_data[2];
    logic [2:0] round_idx[2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    cipher_round_ctrl #(.ROUNDS(4)) u_r4 (
        .clk(clk), .rst(rst[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_mode(in_mode[0]), .key(key[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0]), .round_idx(round_idx[0])
    );

    cipher_round_ctrl #(.ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_mode(in_mode[1]), .key(key[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1]), .round_idx(round_idx[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int nr(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] rev(input logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = v[7-b];
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] k, input int n);
        logic [7:0] r;
        r = k;
        for (int j = 0; j < n; j++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] enc(input logic [7:0] x,
                                       input logic [7:0] k, input int n);
        logic [7:0] v;
        v = x;
        for (int r = 0; r < n; r++) v = rev(8'(v + rotl(k, r)));
        return v;
    endfunction

    function automatic logic [7:0] dec(input logic [7:0] x,
                                       input logic [7:0] k, input int n);
        logic [7:0] v;
        v = x;
        for (int r = n - 1; r >= 0; r--) v = 8'(rev(v) - rotl(k, r));
        return v;
    endfunction

    // Transaction-level model: busy from accept to handshake, result
    // visible after nr(i) round edges.
    bit         m_busy[2];
    bit         m_done[2];
    bit         m_mode[2];
    int         m_el[2];
    logic [7:0] m_res[2];
    logic [7:0] m_out[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_mode[i] <= 1'b0;
                m_el[i]   <= 0;
                m_out[i]  <= 8'h00;
            end else if (!m_busy[i]) begin
                if (in_valid[i]) begin
                    m_busy[i] <= 1'b1;
                    m_el[i]   <= 0;
                    m_mode[i] <= in_mode[i];
                    m_res[i]  <= in_mode[i] ? dec(in_data[i], key[i], nr(i))
                                            : enc(in_data[i], key[i], nr(i));
                end
            end else if (!m_done[i]) begin
                m_el[i] <= m_el[i] + 1;
                if (m_el[i] + 1 == nr(i)) begin
                    m_done[i] <= 1'b1;
                    m_out[i]  <= m_res[i];
                end
            end else if (out_ready[i]) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int ri;
                ri = (m_busy[i] && !m_done[i])
                   ? (m_mode[i] ? nr(i) - 1 - m_el[i] : m_el[i]) : 0;
                chk($sformatf("r%0d_in_ready", nr(i)),
                    32'(in_ready[i]), 32'(!m_busy[i]));
                chk($sformatf("r%0d_out_valid", nr(i)),
                    32'(out_valid[i]), 32'(m_done[i]));
                chk($sformatf("r%0d_busy", nr(i)),
                    32'(busy[i]), 32'(m_busy[i]));
                chk($sformatf("r%0d_out_data", nr(i)),
                    32'(out_data[i]), 32'(m_out[i]));
                chk($sformatf("r%0d_round_idx", nr(i)),
                    32'(round_idx[i]), 32'(ri));
            end
        end
    end

    task automatic wiggle_in(input int i);
        in_data[i]  = 8'($urandom);
        key[i]      = 8'($urandom);
        in_mode[i]  = 1'($urandom_range(1));
        in_valid[i] = 1'($urandom_range(1));
    endtask

    task automatic run_txn(input int i, input logic [7:0] d, input logic m,
                           input logic [7:0] k, input int stall,
                           input bit wig, output logic [7:0] res);
        int n;
        logic [7:0] held;
        in_data[i]   = d;
        in_mode[i]   = m;
        key[i]       = k;
        in_valid[i]  = 1'b1;
        out_ready[i] = 1'b0;
        n = 0;
        while (!in_ready[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        n = 0;
        while (!out_valid[i] && n < 50) begin
            if (wig) wiggle_in(i);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(nr(i)));
        held = out_data[i];
        for (int s = 0; s < stall; s++) begin
            if (wig) wiggle_in(i);
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid[i]), 32'd1);
            chk("stall_data", 32'(out_data[i]), 32'(held));
            chk("stall_in_ready", 32'(in_ready[i]), 32'd0);
        end
        in_valid[i]  = 1'b0;
        res          = out_data[i];
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
        chk("idle_after_hs", 32'(in_ready[i]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] res;
        logic [7:0] d;
        logic [7:0] k;
        logic [7:0] c;
        int acc;
        int first_t;
        int second_t;
        int n;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; in_valid[i] = 1'b0; in_mode[i] = 1'b0;
            out_ready[i] = 1'b0; in_data[i] = 8'h00; key[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_data", 32'(out_data[0]), 32'h00);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_round_idx", 32'(round_idx[0]), 32'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_en = 1'b1;

        chk("pin_enc_r1", 32'(enc(8'h00, 8'h01, 1)), 32'h80);
        chk("pin_enc_r2", 32'(enc(8'h00, 8'h01, 2)), 32'h41);
        chk("pin_enc_r3", 32'(enc(8'h00, 8'h01, 3)), 32'hA2);
        chk("pin_enc_r4", 32'(enc(8'h00, 8'h01, 4)), 32'h55);
        chk("pin_dec_r4", 32'(dec(8'h55, 8'h01, 4)), 32'h00);
        chk("pin_enc_wrap", 32'(enc(8'hFF, 8'hFF, 1)), 32'h7F);
        chk("pin_dec_wrap", 32'(dec(8'h7F, 8'hFF, 1)), 32'hFF);

        run_txn(0, 8'h00, 1'b0, 8'h01, 0, 1'b0, res);
        chk("enc_00_01", 32'(res), 32'h55);
        run_txn(0, 8'h55, 1'b1, 8'h01, 0, 1'b0, res);
        chk("dec_55_01", 32'(res), 32'h00);

        run_txn(1, 8'hFF, 1'b0, 8'hFF, 0, 1'b0, res);
        chk("r1_enc_wrap", 32'(res), 32'h7F);
        run_txn(1, 8'h7F, 1'b1, 8'hFF, 2, 1'b0, res);
        chk("r1_dec_wrap", 32'(res), 32'hFF);

        run_txn(0, 8'h3C, 1'b0, 8'hA5, 10, 1'b1, res);
        chk("backpressure", 32'(res), 32'(enc(8'h3C, 8'hA5, 4)));

        for (int t = 0; t < 200; t++) begin
            d = 8'($urandom);
            k = 8'($urandom);
            run_txn(0, d, 1'b0, k, t % 3, t[0], c);
            run_txn(0, c, 1'b1, k, 0, t[1], res);
            chk("loop_r4", 32'(res), 32'(d));
        end
        for (int t = 0; t < 20; t++) begin
            d = 8'($urandom);
            k = 8'($urandom);
            run_txn(1, d, 1'b0, k, 0, 1'b1, c);
            run_txn(1, c, 1'b1, k, 1, 1'b0, res);
            chk("loop_r1", 32'(res), 32'(d));
        end

        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        acc = 0;
        first_t = -1;
        second_t = -1;
        for (int t = 0; t < 18; t++) begin
            in_data[0] = 8'(t);
            if (in_ready[0]) begin
                if (acc == 0) first_t = t;
                if (acc == 1) second_t = t;
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        chk("tput_accepts", 32'(acc), 32'd3);
        chk("tput_spacing", 32'(second_t - first_t), 32'd6);
        n = 0;
        while (busy[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tput_drain", 32'(busy[0]), 32'd0);
        out_ready[0] = 1'b0;

        run_txn(0, 8'h9E, 1'b0, 8'h37, 0, 1'b0, res);
        in_data[0]  = 8'h00;
        key[0]      = 8'h01;
        in_mode[0]  = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_round_idx", 32'(round_idx[0]), 32'd2);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("midrst_out_data", 32'(out_data[0]), 32'h00);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_valid", 32'(out_valid[0]), 32'd0);
        run_txn(0, 8'h00, 1'b0, 8'h01, 0, 1'b0, res);
        chk("post_rst_enc", 32'(res), 32'h55);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cipher_round_ctrl.md
Name: cipher_round_ctrl

Overview:
Iterative round sequencer for the 8-bit cryptosystem. It accepts one byte plus a mode and key over a valid/ready handshake. It then drives the team's 8-bit bit-reversal block (out[i] = in[7-i]) for ROUNDS iterations, interleaved with key addition or subtraction, and returns the result over a second valid/ready handshake. Encrypt and decrypt are exact inverses, so the block serves as the top-level cipher engine between the UART/byte front end and the output stage.

Parameters:
ROUNDS, 4, number of rounds per byte; legal range 1..8; values outside this range are a synthesis-time error.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream byte available
in_ready  output  1  block can accept a byte; high only in IDLE
in_data  input  8  plaintext (encrypt) or ciphertext (decrypt)
in_mode  input  1  0 = encrypt, 1 = decrypt; sampled at accept
key  input  8  base key; sampled at accept
out_valid  output  1  result available; high only in DONE
out_ready  input  1  downstream accepts result
out_data  output  8  result byte; stable while out_valid is high
busy  output  1  high when state is not IDLE
round_idx  output  3  current round index; 0 outside ROUND

Behaviour:
- Reset is synchronous and active-high; the clock is clk and reset is rst.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0x00, busy = 0, round_idx = 0, internal data/key/mode registers = 0.
- Round key: k_r = key_reg rotated left by r bit positions (r mod 8), for r = 0..ROUNDS-1.
- bitrev() is the instantiated reversal block. The controller only sequences it and has no bit-permutation logic of its own.
- Encrypt round r, with r ascending 0..ROUNDS-1: x <= bitrev((x + k_r) mod 256).
- Decrypt round r, with r descending ROUNDS-1..0: x <= (bitrev(x) - k_r) mod 256.
- All arithmetic is 8-bit. Carry and borrow are discarded, with no saturation.
- State machine, three states:
  - IDLE: in_ready = 1. On in_valid & in_ready: load x <= in_data, key_reg <= key, mode_reg <= in_mode. Set r <= 0 for encrypt or ROUNDS-1 for decrypt. Go to ROUND.
  - ROUND: in_ready = 0. Each edge applies one round to x. The round counter steps +1 for encrypt or -1 for decrypt. After exactly ROUNDS round edges, go to DONE and set out_data <= final x.
  - DONE: out_valid = 1 and out_data is held. On out_valid & out_ready, go to IDLE. If out_ready is low, the block stalls indefinitely in DONE with outputs unchanged.
- Latency: out_valid is first visible exactly ROUNDS edges after the accept edge.
- Throughput: minimum accept-to-accept spacing is ROUNDS+2 edges when out_ready is tied high.
- Changes on in_data, in_mode or key after the accept edge have no effect on the byte in flight.
- in_valid asserted while the block is not in IDLE is ignored; no accept occurs and there is no overflow.
- round_idx reflects r during ROUND only.
- ROUNDS = 1: a single ROUND edge, then DONE.
- Reset asserted in any state, including mid-ROUND and DONE-stalled: on the next edge the block returns to the reset values. The in-flight byte is discarded and no out_valid pulse follows.
- Reset has priority over a simultaneous input or output handshake.

Test Plan:
- ROUNDS=4, encrypt, in_data=0x00, key=0x01 -> out_data=0x55. out_valid rises 4 edges after accept. Intermediate x values are 0x80, 0x41, 0xA2, 0x55.
- ROUNDS=4, decrypt, in_data=0x55, key=0x01 -> out_data=0x00. Round sequence used is r = 3, 2, 1, 0.
- ROUNDS=1, wrap-around:
  - Encrypt in_data=0xFF, key=0xFF -> 0x7F.
  - Decrypt 0x7F with key=0xFF -> 0xFF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1 and out_data stays constant. in_ready stays 0 and in_valid pulses are ignored. Raising out_ready gives the handshake, then IDLE on the next edge.
- Input stability: change key and in_data every cycle during ROUND -> result matches the values sampled at accept. A random 200-byte encrypt-then-decrypt loopback returns every original byte.
- Reset mid-operation: assert rst at round 2 of 4 -> next edge shows IDLE, in_ready=1, out_valid=0, out_data=0x00. A new byte accepted afterwards gives the correct result.
